// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state encoding, opcode constants and instruction field positions for datapath_ctrl.
package ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_LOAD_A, S_LOAD_B, S_EXEC, S_WB_REG, S_WB_IMM
    } state_t;
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;
    localparam int OPC_LSB = 13;
    localparam int OP_LSB  = 11;
    localparam int RN_LSB  = 8;
    localparam int RD_LSB  = 5;
    localparam int SH_LSB  = 3;
    localparam int RM_LSB  = 0;
    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: splits the latched instruction into register/shift/op fields, immediate and class flags.
module instr_decoder
    import ctrl_pkg::*;
(
    input  logic [15:0] i_instr,
    output logic [2:0]  o_rn,
    output logic [2:0]  o_rd,
    output logic [2:0]  o_rm,
    output logic [1:0]  o_sh,
    output logic [1:0]  o_op,
    output logic [15:0] o_imm,
    output logic        o_mov_imm,
    output logic        o_mov_reg,
    output logic        o_alu,
    output logic        o_cmp,
    output logic        o_mvn,
    output logic        o_legal
);
    logic [2:0] w_opc;
    assign w_opc     = i_instr[OPC_LSB +: 3];
    assign o_op      = i_instr[OP_LSB +: 2];
    assign o_rn      = i_instr[RN_LSB +: 3];
    assign o_rd      = i_instr[RD_LSB +: 3];
    assign o_sh      = i_instr[SH_LSB +: 2];
    assign o_rm      = i_instr[RM_LSB +: 3];
    assign o_imm     = sext8(i_instr[7:0]);
    assign o_mov_imm = w_opc == OPC_MOV && o_op == MOV_IMM;
    assign o_mov_reg = w_opc == OPC_MOV && o_op == MOV_REG;
    assign o_alu     = w_opc == OPC_ALU;
    assign o_cmp     = o_alu && o_op == ALU_CMP;
    assign o_mvn     = o_alu && o_op == ALU_MVN;
    assign o_legal   = o_mov_imm || o_mov_reg || o_alu;
endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multicycle FSM sequencing register-file/ALU datapath strobes for one instruction per handshake.
module datapath_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] instr,
    output logic        ready,
    output logic        done,
    output logic        illegal,
    output logic [15:0] imm_out,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop
);
    state_t      r_state, w_next;
    logic [15:0] r_instr;
    logic [2:0]  w_rn, w_rd, w_rm;
    logic [1:0]  w_sh, w_op;
    logic [15:0] w_imm;
    logic        w_mov_imm, w_mov_reg, w_alu, w_cmp, w_mvn, w_legal;

    instr_decoder u_dec (
        .i_instr   (r_instr),
        .o_rn      (w_rn),
        .o_rd      (w_rd),
        .o_rm      (w_rm),
        .o_sh      (w_sh),
        .o_op      (w_op),
        .o_imm     (w_imm),
        .o_mov_imm (w_mov_imm),
        .o_mov_reg (w_mov_reg),
        .o_alu     (w_alu),
        .o_cmp     (w_cmp),
        .o_mvn     (w_mvn),
        .o_legal   (w_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_instr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) r_instr <= instr;
        end
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = start ? S_DECODE : S_IDLE;
            S_DECODE: w_next = !w_legal ? S_IDLE : w_mov_imm ? S_WB_IMM :
                               (w_mov_reg || w_mvn) ? S_LOAD_B : S_LOAD_A;
            S_LOAD_A: w_next = S_LOAD_B;
            S_LOAD_B: w_next = S_EXEC;
            S_EXEC:   w_next = w_cmp ? S_IDLE : S_WB_REG;
            default:  w_next = S_IDLE;
        endcase
    end

    // Unary-style Moore decode: each output is a function of the current state and latched fields.
    always_comb begin
        ready    = r_state == S_IDLE;
        done     = r_state == S_WB_REG || r_state == S_WB_IMM || (r_state == S_EXEC && w_cmp);
        illegal  = r_state == S_DECODE && !w_legal;
        readnum  = r_state == S_LOAD_A ? w_rn : r_state == S_LOAD_B ? w_rm : 3'd0;
        writenum = r_state == S_WB_REG ? w_rd : r_state == S_WB_IMM ? w_rn : 3'd0;
        write    = r_state == S_WB_REG || r_state == S_WB_IMM;
        vsel     = r_state == S_WB_IMM;
        loada    = r_state == S_LOAD_A;
        loadb    = r_state == S_LOAD_B;
        shift    = r_state == S_EXEC ? w_sh : 2'b00;
        ALUop    = (r_state == S_EXEC && w_alu) ? w_op : 2'b00;
        asel     = r_state == S_EXEC && (w_mov_reg || w_mvn);
        bsel     = 1'b0;
        loadc    = r_state == S_EXEC && !w_cmp;
        loads    = r_state == S_EXEC && w_cmp;
    end

    assign imm_out = w_imm;
endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: table vectors, directed corner sequences and random instructions checked against a per-cycle model.
module tb_datapath_ctrl;
    typedef struct packed {
        logic        ready, done, illegal;
        logic [2:0]  readnum, writenum;
        logic        write, loada, loadb, loadc, loads, asel, bsel, vsel;
        logic [1:0]  shift, aluop;
        logic [15:0] imm;
    } obs_t;

    typedef struct {
        logic [15:0] ins;
        int          lat;
        logic        wrote;
        logic [2:0]  wn;
        logic [15:0] imm;
    } vec_t;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [15:0] instr = '0;
    logic        ready, done, illegal, write, loada, loadb, loadc, loads, asel, bsel, vsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;
    logic [15:0] imm_out;
    obs_t        act;
    obs_t        exp_q[$];
    int          checks = 0, errors = 0;
    vec_t        tbl[10];

    datapath_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr),
        .ready(ready), .done(done), .illegal(illegal), .imm_out(imm_out),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop)
    );

    always #5 clk = ~clk;

    always_comb act = {ready, done, illegal, readnum, writenum, write, loada, loadb,
                       loadc, loads, asel, bsel, vsel, shift, ALUop, imm_out};

    // Expected cycle-by-cycle outputs from DECODE through the following idle cycle.
    function automatic void build(input logic [15:0] ins);
        logic [2:0] opc = ins[15:13];
        logic [1:0] op  = ins[12:11];
        logic       mimm = opc == 3'b110 && op == 2'b10;
        logic       mreg = opc == 3'b110 && op == 2'b00;
        logic       alu  = opc == 3'b101;
        logic       alu3 = alu && op != 2'b11;
        logic       cmp  = alu && op == 2'b01;
        obs_t       b, o;
        b = '0;
        b.imm = {{8{ins[7]}}, ins[7:0]};
        exp_q.delete();
        o = b; o.illegal = !(mimm || mreg || alu); exp_q.push_back(o);
        if (mimm) begin
            o = b; o.writenum = ins[10:8]; o.write = 1; o.vsel = 1; o.done = 1; exp_q.push_back(o);
        end else if (mreg || alu) begin
            if (alu3) begin
                o = b; o.readnum = ins[10:8]; o.loada = 1; exp_q.push_back(o);
            end
            o = b; o.readnum = ins[2:0]; o.loadb = 1; exp_q.push_back(o);
            o = b; o.shift = ins[4:3]; o.aluop = alu ? op : 2'b00; o.asel = !alu3;
            o.loadc = !cmp; o.loads = cmp; o.done = cmp; exp_q.push_back(o);
            if (!cmp) begin
                o = b; o.writenum = ins[7:5]; o.write = 1; o.done = 1; exp_q.push_back(o);
            end
        end
        o = b; o.ready = 1; exp_q.push_back(o);
    endfunction

    task automatic chk_obs(input string name, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic run_instr(input logic [15:0] ins, output int lat, output logic wrote,
                             output logic [2:0] wn, output logic [15:0] immv);
        lat = -1; wrote = 0; wn = 0; immv = 0;
        build(ins);
        start = 1; instr = ins;
        @(posedge clk);
        #1 start = 0; instr = 16'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            chk_obs($sformatf("cycle%0d instr %h", i, ins), exp_q[i]);
            if ((done || illegal) && lat < 0) lat = i + 1;
            if (write) begin wrote = 1; wn = writenum; end
            immv = imm_out;
        end
    endtask

    initial begin
        int          lat, nd;
        logic        wrote;
        logic [2:0]  wn;
        logic [15:0] immv, ins;
        obs_t        rst_obs;
        logic [5:0]  mask;
        tbl[0] = '{16'hD3FB, 2, 1'b1, 3'd3, 16'hFFFB};
        tbl[1] = '{16'hA148, 5, 1'b1, 3'd2, 16'h0048};
        tbl[2] = '{16'hA900, 4, 1'b0, 3'd0, 16'h0000};
        tbl[3] = '{16'h0000, 1, 1'b0, 3'd0, 16'h0000};
        tbl[4] = '{16'hC0B2, 4, 1'b1, 3'd5, 16'hFFB2};
        tbl[5] = '{16'hB8E1, 4, 1'b1, 3'd7, 16'hFFE1};
        tbl[6] = '{16'hB683, 5, 1'b1, 3'd4, 16'hFF83};
        tbl[7] = '{16'hC800, 1, 1'b0, 3'd0, 16'h0000};
        tbl[8] = '{16'hE000, 1, 1'b0, 3'd0, 16'h0000};
        tbl[9] = '{16'hD07F, 2, 1'b1, 3'd0, 16'h007F};
        rst_obs = '0; rst_obs.ready = 1;
        repeat (2) @(negedge clk);
        chk_obs("reset state", rst_obs);
        reset = 0;
        @(negedge clk);
        chk_obs("idle after reset", rst_obs);

        foreach (tbl[k]) begin
            run_instr(tbl[k].ins, lat, wrote, wn, immv);
            chk_int($sformatf("latency %h", tbl[k].ins), lat, tbl[k].lat);
            chk_int($sformatf("wrote %h", tbl[k].ins), int'(wrote), int'(tbl[k].wrote));
            if (tbl[k].wrote) chk_int($sformatf("writenum %h", tbl[k].ins), int'(wn), int'(tbl[k].wn));
            chk_int($sformatf("imm %h", tbl[k].ins), int'(immv), int'(tbl[k].imm));
        end

        // Reset asserted while ADD sits in LOAD_B.
        start = 1; instr = 16'hA148;
        @(posedge clk);
        #1 start = 0;
        repeat (3) @(negedge clk);
        chk_int("in LOAD_B before reset", int'(loadb), 1);
        reset = 1;
        @(negedge clk);
        chk_obs("outputs after mid reset", rst_obs);
        reset = 0;
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nd += int'(done) + int'(write);
        end
        chk_int("no done/write after mid reset", nd, 0);
        chk_obs("idle after mid reset", rst_obs);

        // Start pulse while MOV reg is busy must be dropped.
        start = 1; instr = 16'hC0B2;
        @(posedge clk);
        #1 start = 0;
        nd = 0; wn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin start = 1; instr = 16'hD3FB; end
            if (i == 1) start = 0;
            nd += int'(done);
            if (write) wn = writenum;
        end
        chk_int("done count busy start", nd, 1);
        chk_int("writenum busy start", int'(wn), 5);
        chk_int("ready after busy start", int'(ready), 1);

        // Start held high: second MOV imm accepted on the first ready cycle.
        start = 1; instr = 16'hD3FB;
        mask = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mask[i] = done;
            if (i == 4) start = 0;
        end
        chk_int("back-to-back done pattern", int'(mask), int'(6'b010010));
        chk_int("ready after back-to-back", int'(ready), 1);

        for (int n = 0; n < 300; n++) begin
            ins = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       ins[15:13] = 3'b110;
                1, 2:    ins[15:13] = 3'b101;
                default: ;
            endcase
            run_instr(ins, lat, wrote, wn, immv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Multicycle controller that sequences the 16-bit register-file/ALU datapath. It accepts one 16-bit instruction per start/ready handshake, decodes it, and steps the datapath through operand read, execute and write-back by driving its control lines (readnum, writenum, write, loada, loadb, asel, bsel, shift, ALUop, loadc, loads, vsel). It sits between instruction fetch and the datapath and also supplies the sign-extended immediate that feeds datapath_in.

## Interface
- No parameters; data width fixed at 16, register index width fixed at 3.
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; forces IDLE
- start  in  1  request to execute instr; sampled only when ready=1
- instr  in  16  instruction word; captured on the accepted start edge
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse in the final state of each legal instruction
- illegal  out  1  one-cycle pulse in DECODE for an unsupported encoding
- imm_out  out  16  sign-extended instr[7:0] of the latched instruction
- readnum, writenum  out  3  register-file read/write indices
- write, loada, loadb, loadc, loads  out  1  datapath strobes
- asel, bsel, vsel  out  1  datapath mux selects (asel=1 zeroes A; vsel=1 writes datapath_in)
- shift, ALUop  out  2  shifter and ALU operation

## Operation
- Encoding: opcode=instr[15:13], op=[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0], imm8=[7:0].
- Legal: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{sh}; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN Rd,Rm{sh}. All else is illegal.
- States: IDLE, DECODE, LOAD_A, LOAD_B, EXEC, WB_REG, WB_IMM.
- IDLE -> DECODE on start; the instruction register loads at the same edge.
- DECODE -> WB_IMM for MOV imm; LOAD_B for MOV reg and MVN; LOAD_A for ADD, CMP, AND; IDLE if illegal.
- LOAD_A -> LOAD_B -> EXEC. EXEC -> IDLE for CMP, otherwise EXEC -> WB_REG. WB_REG and WB_IMM -> IDLE.
- Outputs are Moore-decoded from state and the latched instruction. Every strobe is 0 outside the states listed here.
  - LOAD_A: readnum=Rn, loada=1.
  - LOAD_B: readnum=Rm, loadb=1.
  - EXEC: shift=sh, bsel=0, ALUop = op for 101-class and 00 for MOV reg, asel=1 for MOV reg and MVN, loadc=1 except CMP, loads=1 only for CMP.
  - WB_REG: writenum=Rd, write=1, vsel=0.
  - WB_IMM: writenum=Rn, write=1, vsel=1.
- Reset values: state IDLE, instruction register 0, ready=1, all strobes/selects 0, readnum=writenum=0, imm_out=0.
- start while ready=0 is ignored and not queued. instr changes after acceptance have no effect.
- Reset mid-instruction: next state is IDLE, with no further strobes and no done. Register contents already written stay written.

## Timing
- Edge 0 accepts start. Latency from that edge to the done cycle: MOV imm 2 cycles (DECODE, WB_IMM); MOV reg/MVN 4; CMP 4; ADD/AND 5.
- ready returns high the cycle after done. Back-to-back: start held high is accepted on the first ready cycle.
- Illegal: illegal=1 in DECODE, ready=1 next cycle. Latency 1, no strobes.
- The shift and ALUop fields are valid only during EXEC. The datapath's loadc/loads capture at the end of EXEC.

## Structure
- Shared package ctrl_pkg holds:
  - state enum;
  - opcode/op localparams (OPC_MOV=3'b110, OPC_ALU=3'b101, ALU_ADD/CMP/AND/MVN);
  - instruction field slice constants.
- One sub-module: instr_decoder. It is combinational and maps the latched instr to Rn/Rd/Rm/sh/op, imm_out, class flags and legal. The FSM and output decode live in datapath_ctrl.

## Test plan
- MOV R3,#-5 (0xD3FB): DECODE, then WB_IMM with writenum=3, vsel=1, write=1, imm_out=0xFFFB, done; ready high on the next cycle.
- ADD R2,R1,R0 LSL1 (0xA148):
  - loada with readnum=1, then loadb with readnum=0;
  - EXEC with shift=01, ALUop=00, loadc=1;
  - WB_REG with writenum=2, write=1;
  - done 5 cycles after accept.
- CMP R1,R0 (0xA900): EXEC has loads=1, loadc=0; done in EXEC; write never asserts.
- Illegal 0x0000: illegal pulses in DECODE; no strobe asserts; ready=1 on the next cycle.
- Assert reset in LOAD_B of an ADD: next cycle is IDLE, all outputs at reset values, and no done.
- Pulse start while busy during a MOV reg: the pulse is ignored, and exactly one done occurs.
